eeprom_config_loader: RTL and testbench

- Sits directly downstream of the EEPROM readout block and drives its read request.
- After reset it issues the read and captures the board ID and baudrate.
- Validates the baudrate and computes the UART bit-period divider with an iterative divider.
- Presents a stable, validated configuration to the UART/comms logic, falling back to defaults on timeout or invalid data.

---
 rtl/eeprom_config_loader_if.sv | 25 ++
 rtl/eeprom_config_loader.sv | 186 ++++++++++++++++++
 tb/tb_eeprom_config_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_config_loader_if.sv
// Read-request / response bus between the EEPROM readout block and the config loader.
// The loader is the master: it issues the read and consumes the returned record.
interface eeprom_config_loader_if;
    logic [10:0] eeprom_addr;
    logic        eeprom_read;
    logic        eeprom_data_ready;
    logic [7:0]  eeprom_id;
    logic [31:0] eeprom_baudrate;

    modport master (
        output eeprom_addr,
        output eeprom_read,
        input  eeprom_data_ready,
        input  eeprom_id,
        input  eeprom_baudrate
    );

    modport slave (
        input  eeprom_addr,
        input  eeprom_read,
        output eeprom_data_ready,
        output eeprom_id,
        output eeprom_baudrate
    );
endinterface

// File: rtl/eeprom_config_loader.sv
// Loads board ID and UART baudrate from EEPROM after reset or on request, validates the
// baudrate, falls back to defaults on timeout/invalid data and derives the UART bit divider.
//
// state    | meaning
// ---------+------------------------------------------------------------
// STARTUP  | post-reset settling delay before the first read
// REQUEST  | one-cycle eeprom_read pulse, arm the response timeout
// WAIT     | wait for rising edge of eeprom_data_ready or timeout
// VALIDATE | range-check captured baudrate, adopt record if good
// FALLBACK | adopt default ID and baudrate
// DIVIDE   | 32-cycle restoring divide for the bit-period divider
// DONE     | configuration stable; start pulse triggers a reload
module eeprom_config_loader #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned STARTUP_DELAY = 1000,
    parameter int unsigned TIMEOUT       = 2000000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned MIN_BAUD      = 1200,
    parameter int unsigned MAX_BAUD      = 3000000,
    parameter int unsigned DEFAULT_BAUD  = 115200,
    parameter logic [7:0]  DEFAULT_ID    = 8'hFF,
    parameter logic [10:0] CFG_ADDR      = 11'h000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    eeprom_config_loader_if.master eep,
    output logic [7:0]             id,
    output logic [31:0]            baudrate,
    output logic [31:0]            baud_div,
    output logic                   config_valid,
    output logic                   config_default,
    output logic                   error,
    output logic                   busy
);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_REQUEST,
        ST_WAIT,
        ST_VALIDATE,
        ST_FALLBACK,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    localparam logic [31:0] CLK_FREQ_W     = 32'(CLK_FREQ);
    localparam logic [31:0] TIMEOUT_W      = 32'(TIMEOUT);
    localparam logic [31:0] MAX_RETRIES_W  = 32'(MAX_RETRIES);
    localparam logic [31:0] MIN_BAUD_W     = 32'(MIN_BAUD);
    localparam logic [31:0] MAX_BAUD_W     = 32'(MAX_BAUD);
    localparam logic [31:0] DEFAULT_BAUD_W = 32'(DEFAULT_BAUD);
    localparam logic [31:0] STARTUP_LAST   = (STARTUP_DELAY == 0) ? 32'd0 : 32'(STARTUP_DELAY - 1);

    state_t      state, state_next;
    logic [31:0] startup_cnt;
    logic [31:0] tmo_cnt;
    logic [31:0] retry_cnt;
    logic        rdy_q;
    logic [7:0]  cap_id;
    logic [31:0] cap_baud;
    logic [31:0] div_num;
    logic [31:0] div_rem;
    logic [30:0] div_quot;
    logic [4:0]  div_cnt;

    logic        rdy_edge;
    logic        tmo_done;
    logic        retry_ok;
    logic        baud_ok;
    logic [32:0] rem_shift;
    logic        q_bit;
    logic [31:0] rem_next;

    assign rdy_edge = eep.eeprom_data_ready & ~rdy_q;
    assign tmo_done = (tmo_cnt == 32'd0);
    assign retry_ok = (retry_cnt + 32'd1) < MAX_RETRIES_W;
    assign baud_ok  = (cap_baud >= MIN_BAUD_W) && (cap_baud <= MAX_BAUD_W);

    // One restoring-division step; baudrate already holds the divisor while in DIVIDE.
    assign rem_shift = {div_rem, div_num[31]};
    assign q_bit     = (rem_shift >= {1'b0, baudrate});
    assign rem_next  = q_bit ? 32'(rem_shift - {1'b0, baudrate}) : rem_shift[31:0];

    assign eep.eeprom_addr = CFG_ADDR;
    assign config_valid    = (state == ST_DONE);
    assign busy            = (state != ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP:  if (startup_cnt == STARTUP_LAST) state_next = ST_REQUEST;
            ST_REQUEST:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (rdy_edge)      state_next = ST_VALIDATE;
                else if (tmo_done) state_next = retry_ok ? ST_REQUEST : ST_FALLBACK;
            end
            ST_VALIDATE: state_next = baud_ok ? ST_DIVIDE : ST_FALLBACK;
            ST_FALLBACK: state_next = ST_DIVIDE;
            ST_DIVIDE:   if (div_cnt == 5'd31) state_next = ST_DONE;
            ST_DONE:     if (start) state_next = ST_REQUEST;
            default:     state_next = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eep.eeprom_read <= 1'b0;
            startup_cnt     <= '0;
            tmo_cnt         <= '0;
            retry_cnt       <= '0;
            rdy_q           <= 1'b0;
            cap_id          <= '0;
            cap_baud        <= '0;
            div_num         <= '0;
            div_rem         <= '0;
            div_quot        <= '0;
            div_cnt         <= '0;
            id              <= DEFAULT_ID;
            baudrate        <= DEFAULT_BAUD_W;
            baud_div        <= '0;
            config_default  <= 1'b0;
            error           <= 1'b0;
        end else begin
            rdy_q           <= eep.eeprom_data_ready;
            eep.eeprom_read <= (state_next == ST_REQUEST);
            case (state)
                ST_STARTUP: startup_cnt <= startup_cnt + 32'd1;
                ST_REQUEST: tmo_cnt <= TIMEOUT_W;
                ST_WAIT: begin
                    // A strobe arriving in the expiry cycle still counts as a response.
                    if (rdy_edge) begin
                        cap_id   <= eep.eeprom_id;
                        cap_baud <= eep.eeprom_baudrate;
                    end else if (tmo_done) begin
                        if (retry_ok) retry_cnt <= retry_cnt + 32'd1;
                        else          error     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                ST_VALIDATE: begin
                    if (baud_ok) begin
                        id             <= cap_id;
                        baudrate       <= cap_baud;
                        config_default <= 1'b0;
                    end
                    div_num <= CLK_FREQ_W + (cap_baud >> 1);
                    div_rem <= '0;
                    div_cnt <= '0;
                end
                ST_FALLBACK: begin
                    id             <= DEFAULT_ID;
                    baudrate       <= DEFAULT_BAUD_W;
                    config_default <= 1'b1;
                    div_num        <= CLK_FREQ_W + (DEFAULT_BAUD_W >> 1);
                    div_rem        <= '0;
                    div_cnt        <= '0;
                end
                ST_DIVIDE: begin
                    div_num  <= {div_num[30:0], 1'b0};
                    div_rem  <= rem_next;
                    div_quot <= {div_quot[29:0], q_bit};
                    div_cnt  <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) baud_div <= {div_quot, q_bit};
                end
                ST_DONE: begin
                    if (start) begin
                        error     <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_config_loader.sv
// Scoreboard bench for eeprom_config_loader: stimulus pushes model results, a monitor
// pops and compares them whenever config_valid rises.
`timescale 1ns/1ps
module tb_eeprom_config_loader;
    localparam int unsigned CLK_FREQ      = 50000000;
    localparam int unsigned STARTUP_DELAY = 20;
    localparam int unsigned TIMEOUT       = 100;
    localparam int unsigned MAX_RETRIES   = 3;
    localparam int unsigned MIN_BAUD      = 1200;
    localparam int unsigned MAX_BAUD      = 3000000;
    localparam int unsigned DEFAULT_BAUD  = 115200;
    localparam logic [7:0]  DEFAULT_ID    = 8'hFF;
    localparam logic [10:0] CFG_ADDR      = 11'h155;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  id;
    logic [31:0] baudrate;
    logic [31:0] baud_div;
    logic        config_valid;
    logic        config_default;
    logic        error;
    logic        busy;

    eeprom_config_loader_if ifc ();

    eeprom_config_loader #(
        .CLK_FREQ(CLK_FREQ), .STARTUP_DELAY(STARTUP_DELAY), .TIMEOUT(TIMEOUT),
        .MAX_RETRIES(MAX_RETRIES), .MIN_BAUD(MIN_BAUD), .MAX_BAUD(MAX_BAUD),
        .DEFAULT_BAUD(DEFAULT_BAUD), .DEFAULT_ID(DEFAULT_ID), .CFG_ADDR(CFG_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eep(ifc),
        .id(id), .baudrate(baudrate), .baud_div(baud_div),
        .config_valid(config_valid), .config_default(config_default),
        .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] baud;
        logic [31:0] div;
        logic        dflt;
        logic        err;
        int          reads;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   read_cnt = 0;
    logic valid_q = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Reference: accept in-range baud, else defaults; divider is CLK_FREQ/baud rounded to nearest.
    function automatic exp_t model(input logic [7:0] rid, input logic [31:0] rbaud,
                                   input bit timed_out, input int reads);
        exp_t e;
        longint unsigned b;
        e.reads = reads;
        if (timed_out) begin
            e.id = DEFAULT_ID; b = DEFAULT_BAUD; e.dflt = 1'b1; e.err = 1'b1;
        end else if (rbaud >= MIN_BAUD && rbaud <= MAX_BAUD) begin
            e.id = rid; b = longint'(rbaud); e.dflt = 1'b0; e.err = 1'b0;
        end else begin
            e.id = DEFAULT_ID; b = DEFAULT_BAUD; e.dflt = 1'b1; e.err = 1'b0;
        end
        e.baud = 32'(b);
        e.div  = 32'((longint'(CLK_FREQ) + b / 2) / b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            read_cnt = 0;
            valid_q  = 1'b0;
        end else begin
            if (ifc.eeprom_read) read_cnt++;
            if (config_valid && !valid_q) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_config: got config_valid rise, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cfg_id", id, mon_e.id);
                    check("cfg_baudrate", baudrate, mon_e.baud);
                    check("cfg_baud_div", baud_div, mon_e.div);
                    check("cfg_default", config_default, mon_e.dflt);
                    check("cfg_error", error, mon_e.err);
                    check("cfg_read_pulses", read_cnt, mon_e.reads);
                    check("cfg_busy", busy, 0);
                end
                read_cnt = 0;
            end
            valid_q = config_valid;
        end
    end

    task automatic wait_read(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (ifc.eeprom_read) ok = 1'b1;
        end
        if (!ok) fail_now("wait_eeprom_read");
    endtask

    task automatic wait_valid(input int budget);
        int  n;
        bit  ok;
        n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (config_valid) ok = 1'b1;
        end
        if (!ok) fail_now("wait_config_valid");
    endtask

    task automatic respond(input int delay, input logic [7:0] rid, input logic [31:0] rbaud);
        repeat (delay) @(negedge clk);
        ifc.eeprom_id         = rid;
        ifc.eeprom_baudrate   = rbaud;
        ifc.eeprom_data_ready = 1'b1;
        @(negedge clk);
        ifc.eeprom_data_ready = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic startup_load(input logic [7:0] rid, input logic [31:0] rbaud);
        int c;
        bit ok;
        @(negedge clk);
        rst_n = 1'b1;
        wait_read(STARTUP_DELAY + 20, c, ok);
        if (ok) begin
            check("startup_delay_min", (c >= STARTUP_DELAY), 1);
            check("startup_delay_max", (c <= STARTUP_DELAY + 2), 1);
            last = model(rid, rbaud, 0, 1);
            exp_q.push_back(last);
            respond(20, rid, rbaud);
            wait_valid(TIMEOUT + 100);
        end
    endtask

    task automatic reload(input logic [7:0] rid, input logic [31:0] rbaud, input int delay);
        int c;
        bit ok;
        pulse_start();
        check("reload_valid_low", config_valid, 0);
        check("reload_busy", busy, 1);
        wait_read(50, c, ok);
        if (ok) begin
            check("hold_id", id, last.id);
            check("hold_baudrate", baudrate, last.baud);
            check("hold_baud_div", baud_div, last.div);
            last = model(rid, rbaud, 0, 1);
            exp_q.push_back(last);
            respond(delay, rid, rbaud);
            wait_valid(TIMEOUT + 100);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_id"}, id, DEFAULT_ID);
        check({tag, "_baudrate"}, baudrate, DEFAULT_BAUD);
        check({tag, "_baud_div"}, baud_div, 0);
        check({tag, "_config_valid"}, config_valid, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_config_default"}, config_default, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_eeprom_read"}, ifc.eeprom_read, 0);
        check({tag, "_eeprom_addr"}, ifc.eeprom_addr, CFG_ADDR);
    endtask

    initial begin
        int c;
        bit ok;
        logic [31:0] b;
        ifc.eeprom_data_ready = 1'b0;
        ifc.eeprom_id         = 8'h00;
        ifc.eeprom_baudrate   = 32'd0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        startup_load(8'h2A, 32'd115200);

        reload(8'h5C, 32'd1000000, 12);
        reload(8'h11, 32'd0, 7);
        reload(8'h22, 32'd4000000, 30);
        reload(8'h33, 32'd1200, 4);
        reload(8'h44, MAX_BAUD, 9);
        reload(8'h45, MAX_BAUD + 1, 9);
        reload(8'h46, MIN_BAUD - 1, 2);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       b = $urandom_range(MIN_BAUD, MAX_BAUD);
                1:       b = $urandom_range(0, MIN_BAUD - 1);
                default: b = MAX_BAUD + 1 + $urandom_range(0, 100000000);
            endcase
            reload(8'($urandom_range(0, 255)), b, $urandom_range(1, 40));
        end

        // No response at all: MAX_RETRIES reads spaced by the timeout, then defaults with error.
        pulse_start();
        wait_read(50, c, ok);
        if (ok) begin
            last = model(8'h00, 32'd0, 1, MAX_RETRIES);
            exp_q.push_back(last);
            for (int r = 1; r < MAX_RETRIES; r++) begin
                wait_read(TIMEOUT + 20, c, ok);
                if (ok) begin
                    check("retry_spacing_min", (c >= TIMEOUT), 1);
                    check("retry_spacing_max", (c <= TIMEOUT + 3), 1);
                end
            end
            wait_valid(2 * TIMEOUT + 100);
        end

        reload(8'h77, 32'd9600, 5);

        // Strobe lands in the cycle where the timeout counter reaches zero.
        reload(8'h88, 32'd57600, TIMEOUT + 1);

        // start during DIVIDE is ignored: one config, no extra read afterwards.
        pulse_start();
        wait_read(50, c, ok);
        if (ok) begin
            last = model(8'h99, 32'd19200, 0, 1);
            exp_q.push_back(last);
            respond(3, 8'h99, 32'd19200);
            repeat (8) @(negedge clk);
            pulse_start();
            wait_valid(TIMEOUT + 100);
            repeat (20) @(negedge clk);
            #1;
            check("ignored_start_reads", read_cnt, 0);
            check("ignored_start_valid", config_valid, 1);
        end

        // Async reset in the middle of a divide.
        pulse_start();
        wait_read(50, c, ok);
        if (ok) begin
            respond(5, 8'hAB, 32'd1000000);
            repeat (10) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check_reset_values("async_reset");
            repeat (3) @(negedge clk);
            startup_load(8'hC3, 32'd38400);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
